// File: rtl/grid_color_mem.sv
// grid_color_mem: colour table for the 4x4 board display.
// Holds one {R,G,B} colour per cell, serves the display's combinational
// lookup, and owns an edited cursor driven by debounced button levels.
// A clear command sweeps all sixteen cells to zero, one cell per cycle.
module grid_color_mem #(
  parameter int BLINK_W  = 24,
  parameter bit BLINK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_color,
  input  logic       btn_clear,
  input  logic [3:0] posicion,
  output logic [2:0] dirColor,
  output logic [3:0] cursor,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  // Button vector order sets action priority: clear > color > up > down > left > right.
  localparam int unsigned B_RIGHT = 0;
  localparam int unsigned B_LEFT  = 1;
  localparam int unsigned B_DOWN  = 2;
  localparam int unsigned B_UP    = 3;
  localparam int unsigned B_COLOR = 4;
  localparam int unsigned B_CLEAR = 5;

  state_t             state_q, state_d;
  logic [3:0]         sweep_q, sweep_d;
  logic [5:0]         btn_lvl;
  logic [5:0]         hist_q;
  logic [5:0]         edges;
  logic [1:0]         col_q, col_d;
  logic [1:0]         row_q, row_d;
  logic [2:0]         cell_q [16];
  logic               wr_en;
  logic [3:0]         wr_idx;
  logic [2:0]         wr_data;
  logic [BLINK_W-1:0] blink_q;
  logic               highlight;

  assign btn_lvl = {btn_clear, btn_color, btn_up, btn_down, btn_left, btn_right};
  assign edges   = btn_lvl & ~hist_q;
  assign cursor  = ~{col_q, row_q};
  assign busy    = (state_q == CLEAR);

  // Next-state, cursor movement and the single cell write port.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    col_d   = col_q;
    row_d   = row_q;
    wr_en   = 1'b0;
    wr_idx  = cursor;
    wr_data = cell_q[cursor] + 3'd1;
    case (state_q)
      IDLE: begin
        if (edges[B_CLEAR]) begin
          state_d = CLEAR;
          sweep_d = '0;
        end else if (edges[B_COLOR]) begin
          wr_en = 1'b1;
        end else if (edges[B_UP]) begin
          row_d = row_q - 2'd1;
        end else if (edges[B_DOWN]) begin
          row_d = row_q + 2'd1;
        end else if (edges[B_LEFT]) begin
          col_d = col_q - 2'd1;
        end else if (edges[B_RIGHT]) begin
          col_d = col_q + 2'd1;
        end
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = sweep_q;
        wr_data = '0;
        sweep_d = sweep_q + 4'd1;
        if (sweep_q == 4'd15) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, sweep counter, button history, cursor, blink counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sweep_q <= '0;
      hist_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      hist_q  <= btn_lvl;
      col_q   <= col_d;
      row_q   <= row_d;
      blink_q <= blink_q + 1'b1;
    end
  end

  // Colour table storage, written by colour actions or the clear sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 16; i++) begin
        cell_q[i] <= '0;
      end
    end else if (wr_en) begin
      cell_q[wr_idx] <= wr_data;
    end
  end

  assign highlight = BLINK_EN && (posicion == cursor) && blink_q[BLINK_W-1];

  // Display lookup, with the cursor cell inverted during the blink phase.
  always_comb begin
    dirColor = cell_q[posicion];
    if (highlight) begin
      dirColor = ~cell_q[posicion];
    end
  end

endmodule

// File: tb/tb_grid_color_mem.sv
// Self-checking bench for grid_color_mem: directed scenarios plus random
// button traffic, all compared against an arithmetic model of the board.
module tb_grid_color_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] btns = '0;  // {clear, color, up, down, left, right}
  logic [3:0] posicion = '0;
  logic [2:0] dirColor;
  logic [3:0] cursor;
  logic       busy;

  always #50 clk = ~clk;

  grid_color_mem #(.BLINK_W(4), .BLINK_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btns[3]),
    .btn_down  (btns[2]),
    .btn_left  (btns[1]),
    .btn_right (btns[0]),
    .btn_color (btns[4]),
    .btn_clear (btns[5]),
    .posicion  (posicion),
    .dirColor  (dirColor),
    .cursor    (cursor),
    .busy      (busy)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model of the board.
  int         m_cell [16];
  int         m_col, m_row, m_blink, m_sweep;
  bit         m_clr;
  logic [5:0] m_hist;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_cursor();
    return 15 - (4 * m_col + m_row);
  endfunction

  function automatic int blink_mask();
    return (m_blink >= 8) ? 7 : 0;
  endfunction

  task automatic model_reset();
    foreach (m_cell[i]) m_cell[i] = 0;
    m_col = 0; m_row = 0; m_blink = 0; m_sweep = 0; m_clr = 0; m_hist = '0;
  endtask

  task automatic model_edge();
    logic [5:0] ed;
    int idx;
    ed      = btns & ~m_hist;
    m_hist  = btns;
    m_blink = (m_blink + 1) % 16;
    if (m_clr) begin
      m_cell[m_sweep] = 0;
      m_sweep++;
      if (m_sweep == 16) m_clr = 0;
    end else if (ed[5]) begin
      m_clr = 1; m_sweep = 0;
    end else if (ed[4]) begin
      idx = m_cursor();
      m_cell[idx] = (m_cell[idx] + 1) % 8;
    end else if (ed[3]) m_row = (m_row + 3) % 4;
    else if (ed[2]) m_row = (m_row + 1) % 4;
    else if (ed[1]) m_col = (m_col + 3) % 4;
    else if (ed[0]) m_col = (m_col + 1) % 4;
  endtask

  task automatic check_all();
    int exp;
    check("cursor", cursor, m_cursor());
    check("busy", busy, m_clr);
    for (int p = 0; p < 16; p++) begin
      posicion = p[3:0];
      #1;
      exp = m_cell[p] ^ ((p == m_cursor()) ? blink_mask() : 0);
      check($sformatf("dirColor[%0d]", p), dirColor, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic press(input logic [5:0] m);
    btns = m;
    tick();
    btns = '0;
    tick();
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic reset_now();
    rst = 1'b0;
    #2;
    model_reset();
    check_all();
    check("rst_cursor", cursor, 15);
    check("rst_busy", busy, 0);
    rst = 1'b1;
  endtask

  task automatic read_cell15(input string tag, input int exp);
    posicion = 4'd15;
    #1;
    check(tag, dirColor ^ ((m_cursor() == 15) ? blink_mask() : 0), exp);
  endtask

  initial begin
    model_reset();
    #5;
    check_all();
    #10;
    rst = 1'b1;

    // Blink phase on the cursor cell with an empty table.
    posicion = 4'd15;
    #1;
    check("blink0", dirColor, 0);
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      model_edge();
      #1;
      posicion = 4'd15;
      #1;
      check($sformatf("blink%0d", n), dirColor, ((n % 16) >= 8) ? 7 : 0);
    end

    // Colour cycling with separate pulses, then a long hold.
    for (int k = 0; k < 9; k++) begin
      press(6'b010000);
      read_cell15("color_seq", (k + 1) % 8);
    end
    btns = 6'b010000;
    repeat (20) tick();
    btns = '0;
    tick();
    read_cell15("color_hold", 2);

    // Cursor wrap-around.
    press(6'b000010); check("wrap_left", cursor, 3);
    press(6'b001000); check("wrap_up", cursor, 0);
    press(6'b000001); check("wrap_right", cursor, 12);
    press(6'b000100); check("wrap_down", cursor, 15);

    // Populate cells 11 and 0, then sweep.
    press(6'b000001);
    press(6'b010000); press(6'b010000);
    press(6'b000001); press(6'b000001);
    press(6'b001000);
    check("pre_clear_cursor", cursor, 0);
    press(6'b010000);
    btns = 6'b100000;
    tick();
    check("busy_k", busy, 1);
    btns = '0;
    for (int j = 1; j <= 16; j++) begin
      if (j == 5) btns = 6'b001000;
      tick();
      check($sformatf("busy_k%0d", j), busy, (j < 16) ? 1 : 0);
    end
    check("clear_cursor", cursor, 0);
    btns = '0;
    tick();

    // Simultaneous edges: only the highest priority acts.
    press(6'b010010); check("sim_color_left", cursor, 0);
    press(6'b001001); check("sim_up_right", cursor, 1);

    // Reset in the middle of a sweep.
    press(6'b010000);
    btns = 6'b100000;
    tick();
    btns = '0;
    repeat (7) tick();
    reset_now();

    // Random button traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(3) == 0) btns[b] = ~btns[b];
      end
      btns[5] = ($urandom_range(15) == 0);
      if ($urandom_range(99) == 0) reset_now();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
